sys_arr_sched: RTL and testbench

Run-level scheduler for the N×N systolic array of FP32 FMA processing elements.
- Accepts one matmul command, gates the 2N edge operand streams with the required diagonal skew and counts exactly k_len operands per lane.
- Waits for every PE to report computation complete, then drains the N² accumulators as one AXI-style result stream and reports status.
- Sits between the operand source buffers and the array edge ports.

---
 rtl/dsp_sys_arr_pkg.sv | 19 +
 rtl/sys_arr_sched_lane_gate.sv | 41 ++++
 rtl/sys_arr_sched.sv | 203 ++++++++++++++++++++
 tb/tb_sys_arr_sched.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_sys_arr_pkg.sv
// Shared types for the systolic-array run scheduler.
package dsp_sys_arr_pkg;

   localparam int DAT_W = 32;

   typedef enum logic [2:0] {
      IDLE,
      STREAM,
      SETTLE,
      DRAIN,
      DONE
   } sched_state_t;

   typedef struct packed {
      logic timeout;
      logic fp_err;
   } sched_status_t;

endpackage

// File: rtl/sys_arr_sched_lane_gate.sv
// One edge lane: zero-latency pass-through gate that admits exactly k_len
// handshakes once the scheduler enables it.
module lane_gate
   import dsp_sys_arr_pkg::*;
#(
   parameter int KW = 9
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             open_en,
   input  logic [KW-1:0]    k_len,
   input  logic             src_valid,
   output logic             src_ready,
   input  logic [DAT_W-1:0] src_dat,
   output logic             dst_valid,
   input  logic             dst_ready,
   output logic [DAT_W-1:0] dst_dat,
   output logic             lane_full
);

   logic [KW-1:0] cnt;
   logic          lane_open;

   // The lane is open while enabled and short of its quota; the beat that
   // completes the quota still passes, the gate shuts on the next cycle.
   assign lane_full = (cnt == k_len);
   assign lane_open = open_en & ~lane_full;
   assign dst_valid = lane_open & src_valid;
   assign src_ready = lane_open & dst_ready;
   assign dst_dat   = lane_open ? src_dat : '0;

   // Count handshakes that passed through the open gate.
   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt <= '0;
      else if (lane_open && src_valid && dst_ready)
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/sys_arr_sched.sv
// Run-level scheduler for the NxN systolic array: skewed operand gating,
// completion settle with watchdog, and row-major accumulator drain.
//
// state  | meaning
// IDLE   | waiting for a start command
// STREAM | edge lanes open with diagonal skew, each passes k_len operands
// SETTLE | waiting for SETTLE_CYC consecutive all-done cycles or watchdog
// DRAIN  | streaming N*N accumulators out on the result port
// DONE   | one-cycle done pulse with status
module sys_arr_sched
   import dsp_sys_arr_pkg::*;
#(
   parameter int   N          = 4,
   parameter int   KMAX       = 256,
   parameter int   SETTLE_CYC = 4,
   parameter int   TMO        = 1024,
   localparam int  KW         = $clog2(KMAX + 1)
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [KW-1:0]          k_len,
   output logic                   busy,
   output logic                   done,
   output logic [1:0]             status,
   output logic                   cmd_err,
   input  logic [N-1:0]           a_src_valid,
   output logic [N-1:0]           a_src_ready,
   input  logic [N*DAT_W-1:0]     a_src_dat,
   input  logic [N-1:0]           b_src_valid,
   output logic [N-1:0]           b_src_ready,
   input  logic [N*DAT_W-1:0]     b_src_dat,
   output logic [N-1:0]           row_valid,
   input  logic [N-1:0]           row_ready,
   output logic [N*DAT_W-1:0]     row_dat,
   output logic [N-1:0]           col_valid,
   input  logic [N-1:0]           col_ready,
   output logic [N*DAT_W-1:0]     col_dat,
   input  logic [N*N-1:0]         pe_done,
   input  logic [N*N-1:0]         pe_err,
   input  logic [N*N*DAT_W-1:0]   pe_accum,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [DAT_W-1:0]       res_dat,
   output logic                   res_last
);

   localparam int NN = N * N;
   localparam int TW = $clog2(N + 1);
   localparam int SW = $clog2(SETTLE_CYC + 1);
   localparam int WW = $clog2(TMO + 1);
   localparam int IW = $clog2(NN);

   sched_state_t  state, state_nxt;
   sched_status_t stat;

   logic [KW-1:0]    k_len_q;
   logic [TW-1:0]    t_q;
   logic [SW-1:0]    run_q, run_nxt;
   logic [WW-1:0]    wd_q, wd_nxt;
   logic [IW-1:0]    idx_q;
   logic             timeout_q, fp_err_q, cmd_err_q;
   logic             k_ok, accept, reject;
   logic             settled, wd_exp, idx_last, res_hs, all_full;
   logic [N-1:0]     open_en, row_full, col_full;
   logic [DAT_W-1:0] accum_arr [NN];

   assign k_ok     = (k_len != '0) && (k_len <= KW'(KMAX));
   assign accept   = (state == IDLE) && start && k_ok;
   assign reject   = (state == IDLE) && start && !k_ok;
   assign all_full = (&row_full) && (&col_full);
   assign run_nxt  = (&pe_done) ? run_q + 1'b1 : '0;
   assign settled  = (run_nxt == SW'(SETTLE_CYC));
   assign wd_nxt   = wd_q + 1'b1;
   assign wd_exp   = (wd_nxt == WW'(TMO));
   assign idx_last = (idx_q == IW'(NN - 1));
   assign res_hs   = res_valid && res_ready;
   assign stat     = '{timeout: timeout_q, fp_err: fp_err_q};
   assign cmd_err  = cmd_err_q;

   for (genvar i = 0; i < N; i++) begin : g_lane
      // Lane i opens i cycles into STREAM; t saturates so it stays enabled.
      assign open_en[i] = (state == STREAM) && (int'(t_q) >= i);

      lane_gate #(.KW(KW)) u_row (
         .clk       (clk),
         .rst       (rst),
         .clr       (accept),
         .open_en   (open_en[i]),
         .k_len     (k_len_q),
         .src_valid (a_src_valid[i]),
         .src_ready (a_src_ready[i]),
         .src_dat   (a_src_dat[i*DAT_W +: DAT_W]),
         .dst_valid (row_valid[i]),
         .dst_ready (row_ready[i]),
         .dst_dat   (row_dat[i*DAT_W +: DAT_W]),
         .lane_full (row_full[i])
      );

      lane_gate #(.KW(KW)) u_col (
         .clk       (clk),
         .rst       (rst),
         .clr       (accept),
         .open_en   (open_en[i]),
         .k_len     (k_len_q),
         .src_valid (b_src_valid[i]),
         .src_ready (b_src_ready[i]),
         .src_dat   (b_src_dat[i*DAT_W +: DAT_W]),
         .dst_valid (col_valid[i]),
         .dst_ready (col_ready[i]),
         .dst_dat   (col_dat[i*DAT_W +: DAT_W]),
         .lane_full (col_full[i])
      );
   end

   for (genvar j = 0; j < NN; j++) begin : g_acc
      assign accum_arr[j] = pe_accum[j*DAT_W +: DAT_W];
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state decode and Moore/Mealy outputs.
   always_comb begin
      state_nxt = state;
      busy      = (state != IDLE);
      done      = 1'b0;
      status    = '0;
      res_valid = 1'b0;
      res_dat   = '0;
      res_last  = 1'b0;
      case (state)
         IDLE: begin
            if (accept)
               state_nxt = STREAM;
         end
         STREAM: begin
            if (all_full)
               state_nxt = SETTLE;
         end
         SETTLE: begin
            if (settled || wd_exp)
               state_nxt = DRAIN;
         end
         DRAIN: begin
            res_valid = 1'b1;
            res_dat   = accum_arr[idx_q];
            res_last  = idx_last;
            if (res_hs && idx_last)
               state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            status    = stat;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Command capture, skew counter, settle/watchdog, error flags, drain index.
   always_ff @(posedge clk) begin
      if (rst) begin
         k_len_q   <= '0;
         t_q       <= '0;
         run_q     <= '0;
         wd_q      <= '0;
         idx_q     <= '0;
         timeout_q <= 1'b0;
         fp_err_q  <= 1'b0;
         cmd_err_q <= 1'b0;
      end else begin
         cmd_err_q <= reject;
         if (accept) begin
            k_len_q   <= k_len;
            t_q       <= '0;
            run_q     <= '0;
            wd_q      <= '0;
            idx_q     <= '0;
            timeout_q <= 1'b0;
            fp_err_q  <= 1'b0;
         end
         if (state == STREAM && t_q != TW'(N))
            t_q <= t_q + 1'b1;
         if (state == SETTLE) begin
            run_q <= run_nxt;
            wd_q  <= wd_nxt;
            if (wd_exp && !settled)
               timeout_q <= 1'b1;
         end
         if ((state == STREAM || state == SETTLE) && (|pe_err))
            fp_err_q <= 1'b1;
         if (state == DRAIN && res_hs)
            idx_q <= idx_last ? '0 : idx_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_sys_arr_sched.sv
// Directed bench for sys_arr_sched: skew table, command rejects, settle,
// watchdog, drain ordering with back-pressure, error status and reset abort.
module tb_sys_arr_sched;

   localparam int N    = 4;
   localparam int NN   = N * N;
   localparam int KMAX = 256;
   localparam int SC   = 4;
   localparam int TMO  = 1024;
   localparam int KW   = $clog2(KMAX + 1);

   logic              clk = 1'b0;
   logic              rst, start;
   logic [KW-1:0]     k_len;
   logic              busy, done, cmd_err;
   logic [1:0]        status;
   logic [N-1:0]      a_src_valid, a_src_ready, b_src_valid, b_src_ready;
   logic [N*32-1:0]   a_src_dat, b_src_dat, row_dat, col_dat;
   logic [N-1:0]      row_valid, row_ready, col_valid, col_ready;
   logic [NN-1:0]     pe_done, pe_err;
   logic [NN*32-1:0]  pe_accum;
   logic              res_valid, res_ready, res_last;
   logic [31:0]       res_dat;

   int n_cmp = 0;
   int n_err = 0;
   int hs_row [N];
   int hs_col [N];
   int base_row [N];
   int base_col [N];

   typedef struct {
      logic [N-1:0] rv;
      logic [N-1:0] cv;
   } vec_t;
   vec_t vt [7];

   always #5 clk = ~clk;

   sys_arr_sched #(.N(N), .KMAX(KMAX), .SETTLE_CYC(SC), .TMO(TMO)) dut (
      .clk(clk), .rst(rst), .start(start), .k_len(k_len),
      .busy(busy), .done(done), .status(status), .cmd_err(cmd_err),
      .a_src_valid(a_src_valid), .a_src_ready(a_src_ready), .a_src_dat(a_src_dat),
      .b_src_valid(b_src_valid), .b_src_ready(b_src_ready), .b_src_dat(b_src_dat),
      .row_valid(row_valid), .row_ready(row_ready), .row_dat(row_dat),
      .col_valid(col_valid), .col_ready(col_ready), .col_dat(col_dat),
      .pe_done(pe_done), .pe_err(pe_err), .pe_accum(pe_accum),
      .res_valid(res_valid), .res_ready(res_ready), .res_dat(res_dat),
      .res_last(res_last)
   );

   initial begin
      for (int i = 0; i < N; i++) begin
         hs_row[i] = 0;
         hs_col[i] = 0;
      end
   end

   // Count edge handshakes per lane.
   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (row_valid[i] && row_ready[i]) hs_row[i] <= hs_row[i] + 1;
         if (col_valid[i] && col_ready[i]) hs_col[i] <= hs_col[i] + 1;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_cmd(input int k);
      start = 1'b1;
      k_len = KW'(k);
      tick();
      start = 1'b0;
   endtask

   task automatic wait_drain(output int n);
      n = 0;
      while (!res_valid && n < 2000) begin
         tick();
         n++;
      end
   endtask

   task automatic snap();
      for (int i = 0; i < N; i++) begin
         base_row[i] = hs_row[i];
         base_col[i] = hs_col[i];
      end
   endtask

   task automatic chk_counts(input int k);
      for (int i = 0; i < N; i++) begin
         chk($sformatf("row%0d handshakes", i), 64'(hs_row[i] - base_row[i]), 64'(k));
         chk($sformatf("col%0d handshakes", i), 64'(hs_col[i] - base_col[i]), 64'(k));
      end
   endtask

   task automatic fast_drain(input logic [1:0] exp_st, input string tag);
      res_ready = 1'b1;
      repeat (NN) tick();
      res_ready = 1'b0;
      #1;
      chk({tag, " done"}, 64'(done), 64'd1);
      chk({tag, " status"}, 64'(status), 64'(exp_st));
      tick();
      chk({tag, " idle after done"}, 64'(busy), 64'd0);
   endtask

   initial begin
      int n;

      vt[0] = '{rv: 4'b0001, cv: 4'b0001};
      vt[1] = '{rv: 4'b0011, cv: 4'b0011};
      vt[2] = '{rv: 4'b0111, cv: 4'b0111};
      vt[3] = '{rv: 4'b1110, cv: 4'b1110};
      vt[4] = '{rv: 4'b1100, cv: 4'b1100};
      vt[5] = '{rv: 4'b1000, cv: 4'b1000};
      vt[6] = '{rv: 4'b0000, cv: 4'b0000};

      rst = 1'b1; start = 1'b0; k_len = '0;
      a_src_valid = '1; b_src_valid = '1; row_ready = '1; col_ready = '1;
      for (int i = 0; i < N; i++) begin
         a_src_dat[i*32 +: 32] = 32'hA000_0000 | i;
         b_src_dat[i*32 +: 32] = 32'hB000_0000 | i;
      end
      for (int k = 0; k < NN; k++) pe_accum[k*32 +: 32] = k;
      pe_done = '1; pe_err = '0; res_ready = 1'b0;

      // Reset values.
      tick(); tick();
      chk("rst busy", 64'(busy), 0);
      chk("rst done", 64'(done), 0);
      chk("rst status", 64'(status), 0);
      chk("rst cmd_err", 64'(cmd_err), 0);
      chk("rst row_valid", 64'(row_valid), 0);
      chk("rst col_valid", 64'(col_valid), 0);
      chk("rst a_src_ready", 64'(a_src_ready), 0);
      chk("rst b_src_ready", 64'(b_src_ready), 0);
      chk("rst row_dat", 64'(row_dat), 0);
      chk("rst col_dat", 64'(col_dat), 0);
      chk("rst res_valid", 64'(res_valid), 0);
      chk("rst res_last", 64'(res_last), 0);
      rst = 1'b0;
      tick();

      // Rejected commands: k_len = 0 and k_len = KMAX+1.
      start_cmd(0);
      chk("k0 cmd_err", 64'(cmd_err), 1);
      chk("k0 busy", 64'(busy), 0);
      tick();
      chk("k0 cmd_err pulse", 64'(cmd_err), 0);
      start_cmd(KMAX + 1);
      chk("kmax+1 cmd_err", 64'(cmd_err), 1);
      chk("kmax+1 busy", 64'(busy), 0);
      tick();
      chk("kmax+1 cmd_err pulse", 64'(cmd_err), 0);
      chk("kmax+1 busy after", 64'(busy), 0);

      // A: k_len = 3 skew table, min settle, toggled drain.
      snap();
      start_cmd(3);
      chk("A busy", 64'(busy), 1);
      chk("A no cmd_err", 64'(cmd_err), 0);
      for (int c = 0; c < 7; c++) begin
         chk($sformatf("A c%0d row_valid", c), 64'(row_valid), 64'(vt[c].rv));
         chk($sformatf("A c%0d col_valid", c), 64'(col_valid), 64'(vt[c].cv));
         chk($sformatf("A c%0d a_src_ready", c), 64'(a_src_ready), 64'(vt[c].rv));
         chk($sformatf("A c%0d b_src_ready", c), 64'(b_src_ready), 64'(vt[c].cv));
         for (int i = 0; i < N; i++) begin
            chk($sformatf("A c%0d row_dat%0d", c, i), 64'(row_dat[i*32 +: 32]),
                vt[c].rv[i] ? 64'(32'hA000_0000 | i) : 64'd0);
            chk($sformatf("A c%0d col_dat%0d", c, i), 64'(col_dat[i*32 +: 32]),
                vt[c].cv[i] ? 64'(32'hB000_0000 | i) : 64'd0);
         end
         tick();
      end
      chk_counts(3);
      chk("A settle row_valid", 64'(row_valid), 0);
      chk("A settle busy", 64'(busy), 1);
      wait_drain(n);
      chk("A settle dwell", 64'(n), 64'(SC));
      for (int k = 0; k < NN; k++) begin
         res_ready = 1'b1;
         #1;
         chk($sformatf("A res_dat %0d", k), 64'(res_dat), 64'(k));
         chk($sformatf("A res_last %0d", k), 64'(res_last), 64'(k == NN - 1));
         tick();
         if (k != NN - 1) begin
            res_ready = 1'b0;
            #1;
            chk($sformatf("A stall valid %0d", k + 1), 64'(res_valid), 1);
            chk($sformatf("A stall dat %0d", k + 1), 64'(res_dat), 64'(k + 1));
            chk($sformatf("A stall last %0d", k + 1), 64'(res_last), 64'(k + 1 == NN - 1));
            tick();
         end
      end
      res_ready = 1'b0;
      #1;
      chk("A done", 64'(done), 1);
      chk("A status", 64'(status), 0);
      chk("A res_valid in done", 64'(res_valid), 0);
      tick();
      chk("A done pulse", 64'(done), 0);
      chk("A busy idle", 64'(busy), 0);
      chk("A status idle", 64'(status), 0);

      // B: PE 9 stays low for 6 settle cycles.
      pe_done = '1;
      pe_done[9] = 1'b0;
      start_cmd(3);
      repeat (3 + N) tick();
      repeat (6) tick();
      pe_done = '1;
      wait_drain(n);
      chk("B drain after rise", 64'(n), 64'(SC));
      fast_drain(2'b00, "B");

      // C: PE 5 stuck low, watchdog.
      pe_done = '1;
      pe_done[5] = 1'b0;
      start_cmd(3);
      repeat (3 + N) tick();
      wait_drain(n);
      chk("C watchdog cycles", 64'(n), 64'(TMO));
      fast_drain(2'b10, "C");
      pe_done = '1;

      // D: single-cycle pe_err mid-stream.
      start_cmd(3);
      tick(); tick();
      pe_err[3] = 1'b1;
      tick();
      pe_err = '0;
      repeat (4) tick();
      wait_drain(n);
      chk("D settle dwell", 64'(n), 64'(SC));
      fast_drain(2'b01, "D");

      // E: reset mid-stream, then a fresh command.
      start_cmd(3);
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("E row_valid", 64'(row_valid), 0);
      chk("E col_valid", 64'(col_valid), 0);
      chk("E a_src_ready", 64'(a_src_ready), 0);
      chk("E b_src_ready", 64'(b_src_ready), 0);
      chk("E busy", 64'(busy), 0);
      snap();
      start_cmd(2);
      chk("E c0 row_valid", 64'(row_valid), 64'b0001);
      repeat (2 + N) tick();
      chk_counts(2);
      wait_drain(n);
      chk("E settle dwell", 64'(n), 64'(SC));
      fast_drain(2'b00, "E");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global time limit: got running expected finished");
      $fatal(1);
   end

endmodule
